mem_access_ctrl: RTL and testbench

//  Sequences data-bus (dbus) transactions for the memory stage of the MIPS pipeline.

---
 rtl/mem_access_ctrl.sv | 100 ++++++++++
 tb/tb_mem_access_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MIPS M-stage data-bus sequencer with alignment checks, strobes and load extraction
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              m_is_store,
  input  logic [1:0]        m_size,
  input  logic              m_signed,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [4:0]        m_dst,
  input  logic              flush,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              stall,
  output logic              res_valid,
  output logic [4:0]        res_dst,
  output logic [DATA_W-1:0] res_data,
  output logic              exc_adel,
  output logic              exc_ades
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
  state_t state, state_n;
  logic [1:0] sz;
  logic mis, go, kill, dead, sgn_q, store_q;
  logic [4:0] dst_q;
  logic [3:0] strb;
  logic [DATA_W-1:0] wrep, ext;
  logic [7:0] b;
  logic [15:0] h;
  assign sz = (m_size == 2'd3) ? 2'd2 : m_size;
  assign mis = (sz == 2'd1 & m_addr[0]) | (sz == 2'd2 & |m_addr[1:0]);
  assign go = state == IDLE & m_valid & !mis & !flush;
  assign dead = kill | flush;
  assign exc_adel = m_valid & mis & !m_is_store;
  assign exc_ades = m_valid & mis & m_is_store;
  assign dreq_valid = state == REQ;
  assign res_valid = state == DONE;
  assign stall = state == REQ | state == WAIT | state == DRAIN | go;
  assign strb = !m_is_store ? 4'b0000 :
                sz == 2'd0 ? 4'b0001 << m_addr[1:0] :
                sz == 2'd1 ? 4'b0011 << m_addr[1:0] : 4'b1111;
  assign wrep = sz == 2'd0 ? {4{m_wdata[7:0]}} : sz == 2'd1 ? {2{m_wdata[15:0]}} : m_wdata;
  assign b = dresp_data[{dreq_addr[1:0], 3'b000} +: 8];
  assign h = dresp_data[{dreq_addr[1], 4'b0000} +: 16];
  assign ext = dreq_size == 2'd0 ? {{24{sgn_q & b[7]}}, b} :
               dreq_size == 2'd1 ? {{16{sgn_q & h[15]}}, h} : dresp_data;
  // A kill seen before addr_ok cannot withdraw the request, so the response is drained instead
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = go ? REQ : IDLE;
      REQ:   if (dresp_addr_ok) state_n = dresp_data_ok ? (dead ? IDLE : DONE) : (dead ? DRAIN : WAIT);
      WAIT:  state_n = dresp_data_ok ? (flush ? IDLE : DONE) : (flush ? DRAIN : WAIT);
      DONE:  state_n = IDLE;
      DRAIN: state_n = dresp_data_ok ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      kill <= 1'b0;
      dreq_addr <= '0;
      dreq_size <= '0;
      dreq_strobe <= '0;
      dreq_data <= '0;
      sgn_q <= 1'b0;
      store_q <= 1'b0;
      dst_q <= '0;
      res_dst <= '0;
      res_data <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        kill <= 1'b0;
        dreq_addr <= m_addr;
        dreq_size <= sz;
        dreq_strobe <= strb;
        dreq_data <= wrep;
        sgn_q <= m_signed;
        store_q <= m_is_store;
        dst_q <= m_dst;
      end else if (state == REQ & flush) kill <= 1'b1;
      if (state_n == DONE) begin
        res_dst <= store_q ? 5'd0 : dst_q;
        res_data <= store_q ? '0 : ext;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized transactions checked against a byte-lane reference model
module tb_mem_access_ctrl;
  logic clk = 0, reset = 1;
  logic m_valid = 0, m_is_store = 0, m_signed = 0, flush = 0;
  logic [1:0] m_size = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, dresp_data = 0;
  logic [4:0] m_dst = 0;
  logic dresp_addr_ok = 0, dresp_data_ok = 0;
  logic dreq_valid, stall, res_valid, exc_adel, exc_ades;
  logic [31:0] dreq_addr, dreq_data, res_data;
  logic [1:0] dreq_size;
  logic [3:0] dreq_strobe;
  logic [4:0] res_dst;
  int checks = 0, failures = 0;
  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_is_store(m_is_store), .m_size(m_size),
    .m_signed(m_signed), .m_addr(m_addr), .m_wdata(m_wdata), .m_dst(m_dst), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .stall(stall), .res_valid(res_valid), .res_dst(res_dst),
    .res_data(res_data), .exc_adel(exc_adel), .exc_ades(exc_ades)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int nb(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] lmask(input int n);
    logic [63:0] m;
    m = (64'd1 << (8 * n)) - 64'd1;
    return m[31:0];
  endfunction
  function automatic logic [3:0] e_strb(input logic st, input logic [1:0] s, input logic [31:0] a);
    int v;
    v = ((1 << nb(s)) - 1) << a[1:0];
    return st ? v[3:0] : 4'b0000;
  endfunction
  function automatic logic [31:0] e_wdata(input logic [1:0] s, input logic [31:0] wd);
    int n;
    n = nb(s);
    return (wd & lmask(n)) * (n == 1 ? 32'h0101_0101 : n == 2 ? 32'h0001_0001 : 32'h1);
  endfunction
  function automatic logic [31:0] e_load(input logic [1:0] s, input logic sg, input logic [31:0] a, input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = nb(s);
    v = (rd >> (8 * a[1:0])) & lmask(n);
    if (sg && v[8*n-1]) v = v | ~lmask(n);
    return v;
  endfunction
  task automatic op(input logic st, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                    input logic [31:0] wd, input logic [4:0] dst, input int ao, input int dd,
                    input logic [31:0] rd, input int fl);
    int n;
    logic mis, killed;
    n = nb(sz);
    mis = (a % n) != 0;
    killed = 0;
    m_valid = 1; m_is_store = st; m_size = sz; m_signed = sg; m_addr = a; m_wdata = wd; m_dst = dst;
    flush = 0; dresp_addr_ok = 0; dresp_data_ok = 0;
    @(negedge clk);
    chk("exc_adel", exc_adel, mis & !st);
    chk("exc_ades", exc_ades, mis & st);
    chk("accept_stall", stall, !mis);
    chk("idle_req", dreq_valid, 0);
    if (mis) begin
      @(posedge clk); #1 m_valid = 0;
      @(negedge clk);
      chk("mis_noreq", dreq_valid, 0);
      chk("mis_stall", stall, 0);
      @(posedge clk); #1;
      return;
    end
    for (int k = 0; k <= ao; k++) begin
      @(posedge clk); #1;
      if (killed) m_valid = 0;
      flush = fl == 1 && k == 0;
      if (flush) killed = 1;
      dresp_addr_ok = k == ao;
      dresp_data_ok = k == ao && dd == 0;
      dresp_data = (k == ao && dd == 0) ? rd : $urandom;
      @(negedge clk);
      chk("req_valid", dreq_valid, 1);
      chk("req_addr", dreq_addr, a);
      chk("req_size", dreq_size, sz == 2'd3 ? 2'd2 : sz);
      chk("req_strobe", dreq_strobe, e_strb(st, sz, a));
      if (st) chk("req_data", dreq_data, e_wdata(sz, wd));
      chk("req_stall", stall, 1);
    end
    for (int j = 1; j <= dd; j++) begin
      @(posedge clk); #1;
      if (killed) m_valid = 0;
      dresp_addr_ok = 0;
      flush = fl == 2 && j == 1;
      if (flush) killed = 1;
      dresp_data_ok = j == dd;
      dresp_data = j == dd ? rd : $urandom;
      @(negedge clk);
      chk("wait_req", dreq_valid, 0);
      chk("wait_stall", stall, 1);
    end
    @(posedge clk); #1;
    if (killed) m_valid = 0;
    flush = 0; dresp_addr_ok = 0; dresp_data_ok = 0;
    @(negedge clk);
    chk("res_valid", res_valid, !killed);
    chk("done_stall", stall, 0);
    chk("done_req", dreq_valid, 0);
    if (!killed) begin
      chk("res_dst", res_dst, st ? 5'd0 : dst);
      if (!st) chk("res_data", res_data, e_load(sz, sg, a, rd));
    end
    @(posedge clk); #1 m_valid = 0;
    @(negedge clk);
    chk("after_res", res_valid, 0);
    chk("after_stall", stall, 0);
    chk("after_req", dreq_valid, 0);
    @(posedge clk); #1;
  endtask
  logic st, sg;
  logic [1:0] sz;
  logic [31:0] a;
  int ao, dd, fl;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", dreq_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_res", res_valid, 0);
    chk("rst_addr", dreq_addr, 0);
    chk("rst_strobe", dreq_strobe, 0);
    chk("rst_res_data", res_data, 0);
    @(posedge clk); #1 reset = 0;
    op(0, 2'd2, 0, 32'h100, 32'h0, 5'd3, 0, 0, 32'hDEAD_BEEF, 0);
    op(0, 2'd0, 1, 32'h103, 32'h0, 5'd4, 0, 0, 32'h80FF_0000, 0);
    op(0, 2'd0, 0, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80FF_0000, 0);
    op(1, 2'd1, 0, 32'h102, 32'h1234, 5'd6, 2, 1, 32'h0, 0);
    op(0, 2'd2, 0, 32'h101, 32'h0, 5'd7, 0, 0, 32'h0, 0);
    op(0, 2'd1, 1, 32'h206, 32'h0, 5'd8, 0, 2, 32'h8001_7FFF, 2);
    op(0, 2'd1, 1, 32'h206, 32'h0, 5'd9, 2, 1, 32'h8001_7FFF, 1);
    op(1, 2'd3, 0, 32'h300, 32'hCAFE_F00D, 5'd10, 1, 0, 32'h0, 0);
    m_valid = 1; m_is_store = 0; m_size = 2'd1; m_signed = 0; m_addr = 32'h402; m_dst = 5'd11;
    @(posedge clk); #1 dresp_addr_ok = 1;
    @(posedge clk); #1 dresp_addr_ok = 0; reset = 1; m_valid = 0;
    @(negedge clk);
    chk("wait_before_rst", stall, 1);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("mid_rst_valid", dreq_valid, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_res", res_valid, 0);
    chk("mid_rst_addr", dreq_addr, 0);
    chk("mid_rst_size", dreq_size, 0);
    chk("mid_rst_dst", res_dst, 0);
    chk("mid_rst_exc", exc_adel | exc_ades, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 80; i++) begin
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = sz == 2'd0 ? a[1:0] : sz == 2'd1 ? {a[1], 1'b0} : 2'b00;
      ao = $urandom_range(0, 3);
      dd = $urandom_range(0, 3);
      fl = $urandom_range(0, 5);
      fl = fl == 4 ? 1 : (fl == 5 && dd > 0) ? 2 : 0;
      op(st, sz, sg, a, $urandom, 5'($urandom_range(0, 31)), ao, dd, $urandom, fl);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
